// File: rtl/l1d_evict_wb_ctrl_if.sv
// rtl/l1d_evict_wb_ctrl_if.sv - evict request, data RAM, write-back and done signal bundle
interface l1d_evict_wb_ctrl_if #(
  parameter int ID_W   = 4,
  parameter int TAG_W  = 20,
  parameter int IDX_W  = 6,
  parameter int WAY_W  = 2,
  parameter int LINE_W = 512,
  parameter int BEAT_W = 128
);
  localparam int ADDR_W = TAG_W + IDX_W + $clog2(LINE_W / 8);

  logic              in_vld;
  logic              in_rdy;
  logic [TAG_W-1:0]  in_tag;
  logic [IDX_W-1:0]  in_index;
  logic [WAY_W-1:0]  in_way;
  logic [ID_W-1:0]   in_mshr_id;

  logic              ram_rd_vld;
  logic              ram_rd_rdy;
  logic [IDX_W-1:0]  ram_rd_index;
  logic [WAY_W-1:0]  ram_rd_way;
  logic              ram_rsp_vld;
  logic [LINE_W-1:0] ram_rsp_data;

  logic              wb_vld;
  logic              wb_rdy;
  logic [ADDR_W-1:0] wb_addr;
  logic [BEAT_W-1:0] wb_data;
  logic              wb_last;

  logic              done_vld;
  logic [ID_W-1:0]   done_id;

  modport master (
    input  in_vld, in_tag, in_index, in_way, in_mshr_id,
    input  ram_rd_rdy, ram_rsp_vld, ram_rsp_data, wb_rdy,
    output in_rdy, ram_rd_vld, ram_rd_index, ram_rd_way,
    output wb_vld, wb_addr, wb_data, wb_last, done_vld, done_id
  );

  modport slave (
    output in_vld, in_tag, in_index, in_way, in_mshr_id,
    output ram_rd_rdy, ram_rsp_vld, ram_rsp_data, wb_rdy,
    input  in_rdy, ram_rd_vld, ram_rd_index, ram_rd_way,
    input  wb_vld, wb_addr, wb_data, wb_last, done_vld, done_id
  );
endinterface

// File: rtl/l1d_evict_wb_ctrl.sv
// rtl/l1d_evict_wb_ctrl.sv - L1D eviction controller: read victim line, stream write-back beats, notify MSHR
// One eviction in flight; note rst_n is active-high here.
module l1d_evict_wb_ctrl #(
  parameter int ID_W   = 4,
  parameter int TAG_W  = 20,
  parameter int IDX_W  = 6,
  parameter int WAY_W  = 2,
  parameter int LINE_W = 512,
  parameter int BEAT_W = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  l1d_evict_wb_ctrl_if.master  bus
);
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int OFS_W      = $clog2(LINE_W / 8);
  localparam int ADDR_W     = TAG_W + IDX_W + OFS_W;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BYTES = BEAT_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    SEND,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  index_q;
  logic [WAY_W-1:0]  way_q;
  logic [ID_W-1:0]   id_q;
  logic [LINE_W-1:0] line_buf;
  logic [CNT_W-1:0]  cnt;
  logic              last_beat;

  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.in_rdy      = 1'b0;
    bus.ram_rd_vld  = 1'b0;
    bus.wb_vld      = 1'b0;
    bus.wb_last     = 1'b0;
    bus.done_vld    = 1'b0;
    case (state)
      IDLE: begin
        // Ready depends on state only; held low while reset is asserted.
        bus.in_rdy = !rst_n;
        if (bus.in_vld) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        bus.ram_rd_vld = 1'b1;
        if (bus.ram_rd_rdy) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.ram_rsp_vld) state_nxt = SEND;
      end
      SEND: begin
        bus.wb_vld  = 1'b1;
        bus.wb_last = last_beat;
        if (bus.wb_rdy && last_beat) state_nxt = DONE;
      end
      DONE: begin
        bus.done_vld = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      tag_q    <= '0;
      index_q  <= '0;
      way_q    <= '0;
      id_q     <= '0;
      line_buf <= '0;
      cnt      <= '0;
    end else begin
      if (state == IDLE && bus.in_vld) begin
        tag_q   <= bus.in_tag;
        index_q <= bus.in_index;
        way_q   <= bus.in_way;
        id_q    <= bus.in_mshr_id;
      end
      // Counter holds on the final beat so it never wraps inside a line.
      if (state == RD_WAIT && bus.ram_rsp_vld) begin
        line_buf <= bus.ram_rsp_data;
        cnt      <= '0;
      end else if (state == SEND && bus.wb_rdy && !last_beat) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.ram_rd_index = index_q;
  assign bus.ram_rd_way   = way_q;
  assign bus.wb_addr      = {tag_q, index_q, {OFS_W{1'b0}}} + ADDR_W'(cnt) * ADDR_W'(BEAT_BYTES);
  assign bus.wb_data      = line_buf[int'(cnt) * BEAT_W +: BEAT_W];
  assign bus.done_id      = id_q;
endmodule

// File: tb/tb_l1d_evict_wb_ctrl.sv
// tb/tb_l1d_evict_wb_ctrl.sv - directed self-checking bench for l1d_evict_wb_ctrl
module tb_l1d_evict_wb_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  logic       rsp_pend = 1'b0;
  logic [5:0] rsp_idx  = '0;
  logic [1:0] rsp_way  = '0;
  logic       force_rsp = 1'b0;

  l1d_evict_wb_ctrl_if bus ();

  l1d_evict_wb_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] beat_pat(input logic [5:0] idx, input logic [1:0] way, input int b);
    return {32'hB0A7_0000 + 32'(b), 24'h0, 2'b00, idx, 30'h0, way, 32'h5A5A_0000 | (32'(b) * 32'h1111)};
  endfunction

  function automatic logic [511:0] make_line(input logic [5:0] idx, input logic [1:0] way);
    logic [511:0] l;
    for (int b = 0; b < 4; b++) l[b*128 +: 128] = beat_pat(idx, way, b);
    return l;
  endfunction

  // RAM model: one-cycle read latency; force_rsp injects a spurious junk response
  always @(posedge clk) begin
    if (rst_n) begin
      rsp_pend <= 1'b0;
    end else begin
      rsp_pend <= bus.ram_rd_vld && bus.ram_rd_rdy;
      if (bus.ram_rd_vld && bus.ram_rd_rdy) begin
        rsp_idx <= bus.ram_rd_index;
        rsp_way <= bus.ram_rd_way;
      end
    end
  end

  assign bus.ram_rsp_vld  = rsp_pend | force_rsp;
  assign bus.ram_rsp_data = force_rsp ? {16{32'hDEAD_BEEF}} : make_line(rsp_idx, rsp_way);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept_req(input logic [19:0] tag, input logic [5:0] idx, input logic [1:0] way,
                            input logic [3:0] id, output int waits);
    bus.in_tag     = tag;
    bus.in_index   = idx;
    bus.in_way     = way;
    bus.in_mshr_id = id;
    bus.in_vld     = 1'b1;
    waits = 0;
    while (!bus.in_rdy && waits < 50) begin
      tick();
      waits++;
    end
    chk("accept_rdy", bus.in_rdy, 1);
    tick();
  endtask

  // Called right after the accepting edge; drives the RAM/write-back handshakes reactively
  task automatic run_to_done(input logic [19:0] tag, input logic [5:0] idx, input logic [1:0] way,
                             input logic [3:0] id, input int rd_stall, input int stall_beat,
                             input int stall_n, input int junk_beat);
    int beat = 0;
    int rd_n = 0;
    int st   = 0;
    int n    = 1;
    bit done_seen = 0;
    while (!done_seen && n < 60) begin
      force_rsp = 1'b0;
      chk("busy_in_rdy", bus.in_rdy, 0);
      if (bus.ram_rd_vld) begin
        chk("rd_index", bus.ram_rd_index, idx);
        chk("rd_way", bus.ram_rd_way, way);
        bus.ram_rd_rdy = (rd_n >= rd_stall);
        rd_n++;
      end
      if (bus.wb_vld) begin
        chk("wb_addr", bus.wb_addr, 32'({tag, idx, 6'h00}) + 32'(beat * 16));
        chk("wb_data", bus.wb_data, beat_pat(idx, way, beat));
        chk("wb_last", bus.wb_last, (beat == 3));
        if (beat == junk_beat) force_rsp = 1'b1;
        if (beat == stall_beat && st < stall_n) begin
          bus.wb_rdy = 1'b0;
          st++;
        end else begin
          bus.wb_rdy = 1'b1;
          beat++;
        end
      end
      if (bus.done_vld) begin
        chk("done_id", bus.done_id, id);
        chk("done_latency", n, 7 + rd_stall + stall_n);
        chk("beats_sent", beat, 4);
        done_seen = 1;
      end
      tick();
      n++;
    end
    force_rsp = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("done_once", bus.done_vld, 0);
    chk("idle_in_rdy", bus.in_rdy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waits;
    rst_n          = 1'b1;
    bus.in_vld     = 1'b0;
    bus.in_tag     = '0;
    bus.in_index   = '0;
    bus.in_way     = '0;
    bus.in_mshr_id = '0;
    bus.ram_rd_rdy = 1'b0;
    bus.wb_rdy     = 1'b0;
    tick();
    tick();
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_ram_rd_vld", bus.ram_rd_vld, 0);
    chk("rst_wb_vld", bus.wb_vld, 0);
    chk("rst_wb_last", bus.wb_last, 0);
    chk("rst_done_vld", bus.done_vld, 0);
    chk("rst_done_id", bus.done_id, 0);
    chk("rst_wb_addr", bus.wb_addr, 0);
    rst_n = 1'b0;
    tick();
    chk("post_rst_in_rdy", bus.in_rdy, 1);

    // Basic eviction, no stalls
    accept_req(20'h12345, 6'h05, 2'd2, 4'd3, waits);
    bus.in_vld = 1'b0;
    run_to_done(20'h12345, 6'h05, 2'd2, 4'd3, 0, -1, 0, -1);

    // Write-back stalled 3 cycles on the second beat
    accept_req(20'hABCDE, 6'h3F, 2'd1, 4'd7, waits);
    bus.in_vld = 1'b0;
    run_to_done(20'hABCDE, 6'h3F, 2'd1, 4'd7, 0, 1, 3, -1);

    // RAM read request stalled 5 cycles
    accept_req(20'h00F0F, 6'h2A, 2'd3, 4'hC, waits);
    bus.in_vld = 1'b0;
    run_to_done(20'h00F0F, 6'h2A, 2'd3, 4'hC, 5, -1, 0, -1);

    // Back-to-back with in_vld held; payload switches to the second request right after accept
    accept_req(20'h55555, 6'h11, 2'd0, 4'd1, waits);
    bus.in_tag     = 20'hAAAAA;
    bus.in_index   = 6'h22;
    bus.in_way     = 2'd3;
    bus.in_mshr_id = 4'd2;
    run_to_done(20'h55555, 6'h11, 2'd0, 4'd1, 0, -1, 0, -1);
    accept_req(20'hAAAAA, 6'h22, 2'd3, 4'd2, waits);
    chk("b2b_accept_waits", waits, 0);
    bus.in_vld = 1'b0;
    run_to_done(20'hAAAAA, 6'h22, 2'd3, 4'd2, 0, -1, 0, -1);

    // Spurious RAM response in IDLE and during SEND
    force_rsp = 1'b1;
    tick();
    force_rsp = 1'b0;
    chk("idle_rsp_in_rdy", bus.in_rdy, 1);
    chk("idle_rsp_rd_vld", bus.ram_rd_vld, 0);
    chk("idle_rsp_wb_vld", bus.wb_vld, 0);
    accept_req(20'h0BEEF, 6'h09, 2'd1, 4'd9, waits);
    bus.in_vld = 1'b0;
    run_to_done(20'h0BEEF, 6'h09, 2'd1, 4'd9, 0, -1, 0, 2);

    // Reset in SEND after the first beat: eviction abandoned without a done pulse
    accept_req(20'h11111, 6'h10, 2'd0, 4'd6, waits);
    bus.in_vld     = 1'b0;
    bus.ram_rd_rdy = 1'b1;
    bus.wb_rdy     = 1'b1;
    waits = 0;
    while (!bus.wb_vld && waits < 20) begin
      tick();
      waits++;
    end
    chk("rst_mid_reach_send", bus.wb_vld, 1);
    tick();
    chk("rst_mid_second_beat_addr", bus.wb_addr, 32'({20'h11111, 6'h10, 6'h00}) + 32'd16);
    rst_n = 1'b1;
    tick();
    chk("rst_mid_wb_vld", bus.wb_vld, 0);
    chk("rst_mid_done_vld", bus.done_vld, 0);
    chk("rst_mid_in_rdy", bus.in_rdy, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mid_no_done", bus.done_vld, 0);
      chk("rst_mid_idle_rdy", bus.in_rdy, 1);
    end
    accept_req(20'hFEDCB, 6'h01, 2'd2, 4'hF, waits);
    bus.in_vld = 1'b0;
    run_to_done(20'hFEDCB, 6'h01, 2'd2, 4'hF, 0, -1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
